ir_frame_sequencer: RTL

Controller for the IR receiver path. It sequences NEC-style frame reception on the demodulated, active-low `rx` line. It times each pulse with a dedicated pulse timer, steps a state machine through leader, 32 data bits and stop, and assembles the bits LSB-first. It checks the command/inverted-command pair and hands the decoded `addr`/`cmd` to the consumer through a one-entry valid/ready output register. Repeat codes re-issue the last accepted command.

---
 rtl/ir_pkg.sv | 31 +++
 rtl/ir_pulse_timer.sv | 51 +++++
 rtl/ir_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ir_pkg
// Shared definitions for the IR frame sequencer: FSM state encodings,
// abort-cause codes, the frame width and the command integrity check.
package ir_pkg;

  // Number of data bits in an NEC frame (addr, ~addr, cmd, ~cmd).
  localparam int FRAME_BITS = 32;
  localparam int IDX_W      = $clog2(FRAME_BITS);

  // FSM state encodings.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LEAD_LOW  = 3'd1;
  localparam state_t ST_LEAD_HIGH = 3'd2;
  localparam state_t ST_BIT_LOW   = 3'd3;
  localparam state_t ST_BIT_HIGH  = 3'd4;
  localparam state_t ST_STOP      = 3'd5;
  localparam state_t ST_CHECK     = 3'd6;

  // Abort causes reported on err_code.
  localparam logic [1:0] ERR_TIMING    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
  localparam logic [1:0] ERR_INTEGRITY = 2'd3;

  // The command byte must be the bitwise inverse of the inverted-command byte.
  // The address inverse byte is deliberately ignored so extended addresses pass.
  function automatic logic cmd_intact(input logic [FRAME_BITS-1:0] sr);
    return sr[23:16] == ~sr[31:24];
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer
// Measures the width of the current rx level in timing ticks.
// A free-running prescaler emits one tick every TICK_DIV clk cycles; the
// width counter advances on each tick, saturates at all-ones and is cleared
// whenever clr is high.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   clr    in  clear the width counter (edge seen or sequencer idle)
//   width  out current width in ticks
module ir_pulse_timer #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] width
);

  // A divider of 1 still needs a one-bit prescaler register; it then stays 0
  // and every cycle is a tick.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    presc_reg;
  logic [CNT_W-1:0] width_reg;
  logic             tick;

  assign tick  = (presc_reg == PRESC_LAST);
  assign width = width_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      width_reg <= '0;
    end else if (tick && (width_reg != {CNT_W{1'b1}})) begin
      width_reg <= width_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ir_frame_sequencer.sv
// ir_frame_sequencer
// Receives NEC-style IR frames on the demodulated active-low rx line,
// classifies each pulse width, assembles 32 bits LSB-first, checks the
// command/inverted-command pair and presents addr/cmd through a one-entry
// valid/ready output register. Repeat codes re-issue the last good frame.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   rx                  asynchronous IR input, idle high
//   cmd_ready           consumer ready
//   cmd_valid           output register holds an unconsumed result
//   cmd_data/addr_data  decoded command / address byte
//   cmd_repeat          result came from a repeat code
//   err_pulse/err_code  one-cycle abort strobe and its cause
//   drop_pulse          one-cycle strobe when a result is lost (register full)
//   busy                sequencer is not idle
module ir_frame_sequencer
  import ir_pkg::*;
#(
  parameter int TICK_DIV      = 50,
  parameter int CNT_W         = 14,
  parameter int LEAD_LOW_MIN  = 8000,
  parameter int LEAD_HIGH_MIN = 4000,
  parameter int REP_HIGH_MIN  = 2000,
  parameter int BIT_LOW_MAX   = 800,
  parameter int BIT_ONE_MIN   = 1100,
  parameter int TIMEOUT       = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic [7:0] addr_data,
  output logic       cmd_repeat,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic       drop_pulse,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LEAD_LOW_W  = CNT_W'(LEAD_LOW_MIN);
  localparam logic [CNT_W-1:0] LEAD_HIGH_W = CNT_W'(LEAD_HIGH_MIN);
  localparam logic [CNT_W-1:0] REP_HIGH_W  = CNT_W'(REP_HIGH_MIN);
  localparam logic [CNT_W-1:0] BIT_LOW_W   = CNT_W'(BIT_LOW_MAX);
  localparam logic [CNT_W-1:0] BIT_ONE_W   = CNT_W'(BIT_ONE_MIN);
  localparam logic [CNT_W-1:0] TIMEOUT_W   = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_BITS - 1);

  // Input synchronizer and edge strobes.
  logic rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic fall, rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rx;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  assign fall = rx_prev_reg & ~rx_s2_reg;
  assign rise = ~rx_prev_reg & rx_s2_reg;

  // Pulse timer: held clear while idle so the leader low is timed from its fall.
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] width;
  logic             timer_clr;

  assign timer_clr = fall | rise | (state_reg == ST_IDLE);

  ir_pulse_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .width (width)
  );

  // Sequencer.
  logic [FRAME_BITS-1:0] sr_reg, sr_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic                  err_set;
  logic [1:0]            err_code_next;
  logic                  rep_req;
  logic                  frame_load;

  always_comb begin
    state_next    = state_reg;
    sr_next       = sr_reg;
    bit_idx_next  = bit_idx_reg;
    err_set       = 1'b0;
    err_code_next = ERR_TIMING;
    rep_req       = 1'b0;
    frame_load    = 1'b0;

    if ((state_reg != ST_IDLE) && (width == TIMEOUT_W)) begin
      err_set       = 1'b1;
      err_code_next = ERR_TIMEOUT;
      state_next    = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fall) state_next = ST_LEAD_LOW;
        end
        ST_LEAD_LOW: begin
          if (rise) begin
            if (width >= LEAD_LOW_W) begin
              state_next = ST_LEAD_HIGH;
            end else begin
              err_set    = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_LEAD_HIGH: begin
          if (fall) begin
            if (width >= LEAD_HIGH_W) begin
              state_next   = ST_BIT_LOW;
              bit_idx_next = '0;
              sr_next      = '0;
            end else if (width >= REP_HIGH_W) begin
              rep_req    = 1'b1;
              state_next = ST_IDLE;
            end else begin
              err_set    = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_BIT_LOW: begin
          if (rise) begin
            if (width <= BIT_LOW_W) begin
              state_next = ST_BIT_HIGH;
            end else begin
              err_set    = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_BIT_HIGH: begin
          if (fall) begin
            // Bits arrive LSB-first, so shift in from the top.
            sr_next      = {(width >= BIT_ONE_W), sr_reg[FRAME_BITS-1:1]};
            bit_idx_next = bit_idx_reg + 1'b1;
            state_next   = (bit_idx_reg == LAST_IDX) ? ST_STOP : ST_BIT_LOW;
          end
        end
        ST_STOP: begin
          if (rise) state_next = ST_CHECK;
        end
        ST_CHECK: begin
          if (cmd_intact(sr_reg)) begin
            frame_load = 1'b1;
          end else begin
            err_set       = 1'b1;
            err_code_next = ERR_INTEGRITY;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Last accepted frame, replayed by repeat codes.
  logic       last_valid_reg;
  logic [7:0] last_addr_reg, last_cmd_reg;
  logic       rep_pend_reg;

  // Output register.
  logic       cmd_valid_reg, cmd_repeat_reg;
  logic [7:0] cmd_data_reg, addr_data_reg;
  logic       err_pulse_reg, drop_pulse_reg;
  logic [1:0] err_code_reg;

  logic       load, handshake;
  logic [7:0] load_addr, load_cmd;

  // A repeat is serviced one cycle after its fall strobe, from the stored frame.
  assign load      = frame_load | rep_pend_reg;
  assign load_addr = rep_pend_reg ? last_addr_reg : sr_reg[7:0];
  assign load_cmd  = rep_pend_reg ? last_cmd_reg  : sr_reg[23:16];
  assign handshake = cmd_valid_reg & cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      sr_reg         <= '0;
      bit_idx_reg    <= '0;
      rep_pend_reg   <= 1'b0;
      last_valid_reg <= 1'b0;
      last_addr_reg  <= '0;
      last_cmd_reg   <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_data_reg   <= '0;
      addr_data_reg  <= '0;
      cmd_repeat_reg <= 1'b0;
      err_pulse_reg  <= 1'b0;
      err_code_reg   <= '0;
      drop_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sr_reg         <= sr_next;
      bit_idx_reg    <= bit_idx_next;
      rep_pend_reg   <= rep_req & last_valid_reg;
      err_pulse_reg  <= err_set;
      err_code_reg   <= err_set ? err_code_next : 2'd0;
      drop_pulse_reg <= 1'b0;

      if (frame_load) begin
        last_valid_reg <= 1'b1;
        last_addr_reg  <= sr_reg[7:0];
        last_cmd_reg   <= sr_reg[23:16];
      end

      if (load) begin
        if (!cmd_valid_reg || handshake) begin
          cmd_valid_reg  <= 1'b1;
          cmd_data_reg   <= load_cmd;
          addr_data_reg  <= load_addr;
          cmd_repeat_reg <= rep_pend_reg;
        end else begin
          drop_pulse_reg <= 1'b1;
        end
      end else if (handshake) begin
        cmd_valid_reg <= 1'b0;
      end
    end
  end

  assign cmd_valid  = cmd_valid_reg;
  assign cmd_data   = cmd_data_reg;
  assign addr_data  = addr_data_reg;
  assign cmd_repeat = cmd_repeat_reg;
  assign err_pulse  = err_pulse_reg;
  assign err_code   = err_code_reg;
  assign drop_pulse = drop_pulse_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule
